// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the GPIO interrupt core: register word addresses and
// interrupt configuration encodings.
package gpio_irq_pkg;

    localparam int unsigned ADDR_DIR      = 0;
    localparam int unsigned ADDR_OUT      = 1;
    localparam int unsigned ADDR_IN       = 2;
    localparam int unsigned ADDR_IRQ_EN   = 3;
    localparam int unsigned ADDR_IRQ_TYPE = 4;
    localparam int unsigned ADDR_IRQ_POL  = 5;
    localparam int unsigned ADDR_IRQ_BOTH = 6;
    localparam int unsigned ADDR_STATUS   = 7;

    typedef enum logic {
        EDGE  = 1'b0,
        LEVEL = 1'b1
    } irq_type_e;

    typedef enum logic {
        RISE_HIGH = 1'b0,
        FALL_LOW  = 1'b1
    } irq_pol_e;

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin debounce filter; compiled only when GPIO_DEBOUNCE_EN is defined.
// The output follows the input once they have differed for DB_CYCLES cycles in a row.
`ifdef GPIO_DEBOUNCE_EN
module gpio_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [7:0] r_cnt;
    logic       r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_q   <= 1'b0;
        end else if (i_d != r_q) begin
            if (r_cnt == 8'(DB_CYCLES - 1)) begin
                r_q   <= i_d;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end else begin
            // any agreement restarts the run of mismatches
            r_cnt <= '0;
        end
    end

    assign o_q = r_q;

endmodule
`endif

// File: rtl/gpio_irq_core.sv
// Parametrised GPIO core: direction/output registers, synchronised inputs and
// sticky maskable interrupts. Optional input debounce under GPIO_DEBOUNCE_EN.
module gpio_irq_core
    import gpio_irq_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH = 8,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned DB_CYCLES  = 4
) (
    input  logic                  pclk,
    input  logic                  p_reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [GPIO_WIDTH-1:0] wdata,
    output logic [GPIO_WIDTH-1:0] rdata,
    input  logic [GPIO_WIDTH-1:0] gpio_pin_in,
    output logic [GPIO_WIDTH-1:0] gpio_pin_out,
    output logic [GPIO_WIDTH-1:0] n_gpio_pin_oe,
    output logic                  irq
);

    if (GPIO_WIDTH < 1 || GPIO_WIDTH > 32) begin : g_bad_width
        $fatal(1, "GPIO_WIDTH out of range");
    end
    if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_db
        $fatal(1, "DB_CYCLES out of range");
    end

    logic [GPIO_WIDTH-1:0] r_dir;
    logic [GPIO_WIDTH-1:0] r_out;
    logic [GPIO_WIDTH-1:0] r_irq_en;
    logic [GPIO_WIDTH-1:0] r_irq_type;
    logic [GPIO_WIDTH-1:0] r_irq_pol;
    logic [GPIO_WIDTH-1:0] r_irq_both;
    logic [GPIO_WIDTH-1:0] r_status;
    logic [GPIO_WIDTH-1:0] r_sync1;
    logic [GPIO_WIDTH-1:0] r_sync2;
    logic [GPIO_WIDTH-1:0] r_prev;
    logic [GPIO_WIDTH-1:0] r_rdata;

    logic [GPIO_WIDTH-1:0] w_det;
    logic [GPIO_WIDTH-1:0] w_hit;
    logic [GPIO_WIDTH-1:0] w_w1c;
    logic [GPIO_WIDTH-1:0] w_status_d;
    logic [GPIO_WIDTH-1:0] w_rd_val;

`ifdef GPIO_DEBOUNCE_EN
    for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_db
        gpio_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .i_clk(pclk),
            .i_rst(p_reset),
            .i_d  (r_sync2[g]),
            .o_q  (w_det[g])
        );
    end
`else
    assign w_det = r_sync2;
`endif

    // Per-pin trigger condition; prev holds the detector input from one cycle earlier.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < GPIO_WIDTH; i++) begin
            if (irq_type_e'(r_irq_type[i]) == LEVEL) begin
                w_hit[i] = (irq_pol_e'(r_irq_pol[i]) == FALL_LOW) ? ~w_det[i] : w_det[i];
            end else if (r_irq_both[i]) begin
                w_hit[i] = w_det[i] ^ r_prev[i];
            end else if (irq_pol_e'(r_irq_pol[i]) == FALL_LOW) begin
                w_hit[i] = ~w_det[i] & r_prev[i];
            end else begin
                w_hit[i] = w_det[i] & ~r_prev[i];
            end
        end
    end

    assign w_w1c      = (wr_en && addr == ADDR_W'(ADDR_STATUS)) ? wdata : '0;
    // set is OR-ed after the clear so a same-cycle event wins over W1C
    assign w_status_d = (r_status & ~w_w1c) | (w_hit & r_irq_en);

    always_comb begin
        w_rd_val = '0;
        case (addr)
            ADDR_W'(ADDR_DIR):      w_rd_val = r_dir;
            ADDR_W'(ADDR_OUT):      w_rd_val = r_out;
            ADDR_W'(ADDR_IN):       w_rd_val = w_det;
            ADDR_W'(ADDR_IRQ_EN):   w_rd_val = r_irq_en;
            ADDR_W'(ADDR_IRQ_TYPE): w_rd_val = r_irq_type;
            ADDR_W'(ADDR_IRQ_POL):  w_rd_val = r_irq_pol;
            ADDR_W'(ADDR_IRQ_BOTH): w_rd_val = r_irq_both;
            ADDR_W'(ADDR_STATUS):   w_rd_val = r_status;
            default:                w_rd_val = '0;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            r_dir      <= '0;
            r_out      <= '0;
            r_irq_en   <= '0;
            r_irq_type <= '0;
            r_irq_pol  <= '0;
            r_irq_both <= '0;
            r_status   <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= '0;
            r_rdata    <= '0;
        end else begin
            r_sync1  <= gpio_pin_in;
            r_sync2  <= r_sync1;
            r_prev   <= w_det;
            r_status <= w_status_d;
            if (rd_en) begin
                r_rdata <= w_rd_val;
            end
            if (wr_en) begin
                case (addr)
                    ADDR_W'(ADDR_DIR):      r_dir      <= wdata;
                    ADDR_W'(ADDR_OUT):      r_out      <= wdata;
                    ADDR_W'(ADDR_IRQ_EN):   r_irq_en   <= wdata;
                    ADDR_W'(ADDR_IRQ_TYPE): r_irq_type <= wdata;
                    ADDR_W'(ADDR_IRQ_POL):  r_irq_pol  <= wdata;
                    ADDR_W'(ADDR_IRQ_BOTH): r_irq_both <= wdata;
                    default: ;
                endcase
            end
        end
    end

    assign rdata         = r_rdata;
    assign gpio_pin_out  = r_out;
    assign n_gpio_pin_oe = ~r_dir;
    assign irq           = |(r_status & r_irq_en);

endmodule

// File: tb/tb_gpio_irq_core.sv
// Directed and randomised bench for gpio_irq_core (default build, 8 pins),
// checked against a pin-history reference model.
module tb_gpio_irq_core;

    logic       pclk = 1'b0;
    logic       p_reset = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [2:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic [7:0] gpio_pin_in = '0;
    logic [7:0] gpio_pin_out;
    logic [7:0] n_gpio_pin_oe;
    logic       irq;

    gpio_irq_core #(
        .GPIO_WIDTH(8),
        .ADDR_W    (3),
        .DB_CYCLES (4)
    ) dut (
        .pclk         (pclk),
        .p_reset      (p_reset),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .gpio_pin_in  (gpio_pin_in),
        .gpio_pin_out (gpio_pin_out),
        .n_gpio_pin_oe(n_gpio_pin_oe),
        .irq          (irq)
    );

    always #5 pclk = ~pclk;

    int unsigned n_pass = 0;
    int unsigned n_fail = 0;
    int unsigned n_total = 0;

    logic [7:0] pins = '0;

    // Reference model: registers by name plus the last three pin samples.
    logic [7:0] m_dir, m_out, m_en, m_type, m_pol, m_both, m_status, m_rdata;
    logic [7:0] hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_reg(input logic [2:0] a, input logic [7:0] in_v);
        case (a)
            3'd0: return m_dir;
            3'd1: return m_out;
            3'd2: return in_v;
            3'd3: return m_en;
            3'd4: return m_type;
            3'd5: return m_pol;
            3'd6: return m_both;
            default: return m_status;
        endcase
    endfunction

    task automatic model_reset();
        m_dir = '0; m_out = '0; m_en = '0; m_type = '0;
        m_pol = '0; m_both = '0; m_status = '0; m_rdata = '0;
        hist = '{8'h00, 8'h00, 8'h00};
    endtask

    // hist[1] is the pin value seen by the detector now, hist[2] the value one cycle before.
    task automatic model_edge(input bit rst, input bit wr, input bit rd,
                              input logic [2:0] a, input logic [7:0] wd, input logic [7:0] pin);
        logic [7:0] cur, old, hit, clr;
        if (rst) begin
            model_reset();
            return;
        end
        cur = hist[1];
        old = hist[2];
        hit = '0;
        for (int i = 0; i < 8; i++) begin
            if (m_type[i]) hit[i] = m_pol[i] ? !cur[i] : cur[i];
            else if (m_both[i]) hit[i] = cur[i] != old[i];
            else if (m_pol[i]) hit[i] = !cur[i] && old[i];
            else hit[i] = cur[i] && !old[i];
        end
        if (rd) m_rdata = m_reg(a, cur);
        clr = (wr && a == 3'd7) ? wd : 8'h00;
        m_status = (m_status & ~clr) | (hit & m_en);
        if (wr) begin
            case (a)
                3'd0: m_dir = wd;
                3'd1: m_out = wd;
                3'd3: m_en = wd;
                3'd4: m_type = wd;
                3'd5: m_pol = wd;
                3'd6: m_both = wd;
                default: ;
            endcase
        end
        hist.push_front(pin);
        void'(hist.pop_back());
    endtask

    task automatic step(input bit rst, input bit wr, input bit rd,
                        input logic [2:0] a, input logic [7:0] wd);
        p_reset = rst;
        wr_en = wr;
        rd_en = rd;
        addr = a;
        wdata = wd;
        gpio_pin_in = pins;
        @(posedge pclk);
        model_edge(rst, wr, rd, a, wd, pins);
        #1;
        check("pin_out", {24'h0, gpio_pin_out}, {24'h0, m_out});
        check("pin_oe_n", {24'h0, n_gpio_pin_oe}, {24'h0, ~m_dir});
        check("irq", {31'h0, irq}, {31'h0, |(m_status & m_en)});
        check("rdata", {24'h0, rdata}, {24'h0, m_rdata});
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b0, 1'b0, 1'b1, a, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    initial begin
        model_reset();

        // reset and read-back of every address
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        check("rst_oe_n", {24'h0, n_gpio_pin_oe}, 32'hFF);
        check("rst_irq", {31'h0, irq}, 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            check($sformatf("rst_read%0d", a), {24'h0, rdata}, 32'h0);
        end

        // output path
        wr(3'd0, 8'h0F);
        wr(3'd1, 8'hA5);
        check("out_data", {24'h0, gpio_pin_out}, 32'hA5);
        check("out_oe_n", {24'h0, n_gpio_pin_oe}, 32'hF0);
        rd(3'd1);
        check("read_out", {24'h0, rdata}, 32'hA5);

        // rising edge on pin0: status at edge k+2
        wr(3'd3, 8'h01);
        pins[0] = 1'b1;
        idle(1);
        check("rise_k", {31'h0, irq}, 32'h0);
        idle(1);
        check("rise_k1", {31'h0, irq}, 32'h0);
        rd(3'd2);
        check("in_pin0", {24'h0, rdata}, 32'h01);
        check("rise_k2", {31'h0, irq}, 32'h1);
        wr(3'd7, 8'h01);
        check("rise_w1c", {31'h0, irq}, 32'h0);
        pins[0] = 1'b0;
        idle(4);
        check("fall_ignored", {31'h0, irq}, 32'h0);

        // both edges on pin7, second set coincides with W1C
        wr(3'd3, 8'h81);
        wr(3'd6, 8'h80);
        pins[7] = 1'b1;
        idle(3);
        check("both_first", {31'h0, irq}, 32'h1);
        wr(3'd7, 8'h80);
        check("both_clr", {31'h0, irq}, 32'h0);
        idle(7);
        pins[7] = 1'b0;
        idle(2);
        wr(3'd7, 8'h80);
        check("both_setwins", {31'h0, irq}, 32'h1);
        rd(3'd7);
        check("both_status", {24'h0, rdata}, 32'h80);
        wr(3'd7, 8'h80);

        // level-low on pin1 cannot be cleared while active
        wr(3'd3, 8'h83);
        wr(3'd4, 8'h02);
        wr(3'd5, 8'h02);
        idle(1);
        check("lvl_set", {31'h0, irq}, 32'h1);
        wr(3'd7, 8'h02);
        rd(3'd7);
        check("lvl_sticky", {24'h0, rdata}, 32'h02);
        pins[1] = 1'b1;
        idle(3);
        wr(3'd7, 8'h02);
        rd(3'd7);
        check("lvl_cleared", {24'h0, rdata}, 32'h00);

        // reset mid-operation discards a concurrent write
        step(1'b1, 1'b1, 1'b0, 3'd0, 8'hFF);
        check("midrst_oe_n", {24'h0, n_gpio_pin_oe}, 32'hFF);
        check("midrst_out", {24'h0, gpio_pin_out}, 32'h00);
        pins = '0;
        idle(3);

        // randomised traffic against the model
        for (int c = 0; c < 1500; c++) begin
            logic [7:0] flip;
            flip = '0;
            for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(0, 5) == 0);
            pins = pins ^ flip;
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 0),
                 3'($urandom_range(0, 7)),
                 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
